// File: rtl/tile_mapper.sv
// tile_mapper
// Maps a raster pixel stream onto a grid of CELL_W x CELL_H glyph cells.
// Each qualified input pixel produces, one cycle later, the tile coordinates
// of that pixel, its offset inside the cell, and a window-enable flag.
// Positions are tracked purely with counters (no divide/modulo).
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   pix_valid             a pixel is presented this cycle
//   sof, sol              start of frame / start of line (qualified by pix_valid)
//   cfg_x0/x1, cfg_y0/y1  staged window bounds in tiles (inclusive)
//   cfg_load              capture cfg_* into the shadow bounds
//   tile_x, tile_y        tile coordinates of the output pixel
//   cell_x, cell_y        offset of the output pixel inside its cell
//   out_valid             output pixel is valid
//   pixel_en              output pixel lies inside the active window
//   tile_ovf              sticky per frame: a tile counter saturated
module tile_mapper #(
  parameter int CELL_W = 8,
  parameter int CELL_H = 8,
  parameter int TX_W   = 6,
  parameter int TY_W   = 6,
  parameter int WX0    = 1,
  parameter int WX1    = 39,
  parameter int WY0    = 3,
  parameter int WY1    = 37,
  localparam int CX_W  = $clog2(CELL_W),
  localparam int CY_W  = $clog2(CELL_H)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            pix_valid,
  input  logic            sof,
  input  logic            sol,
  input  logic [TX_W-1:0] cfg_x0,
  input  logic [TX_W-1:0] cfg_x1,
  input  logic [TY_W-1:0] cfg_y0,
  input  logic [TY_W-1:0] cfg_y1,
  input  logic            cfg_load,
  output logic [TX_W-1:0] tile_x,
  output logic [TY_W-1:0] tile_y,
  output logic [CX_W-1:0] cell_x,
  output logic [CY_W-1:0] cell_y,
  output logic            out_valid,
  output logic            pixel_en,
  output logic            tile_ovf
);

  localparam logic [CX_W-1:0] CX_LAST = CX_W'(CELL_W - 1);
  localparam logic [CY_W-1:0] CY_LAST = CY_W'(CELL_H - 1);
  localparam logic [TX_W-1:0] RST_X0  = TX_W'(WX0);
  localparam logic [TX_W-1:0] RST_X1  = TX_W'(WX1);
  localparam logic [TY_W-1:0] RST_Y0  = TY_W'(WY0);
  localparam logic [TY_W-1:0] RST_Y1  = TY_W'(WY1);

  // The position counters double as the registered coordinate outputs:
  // after a pixel is absorbed they hold exactly that pixel's coordinates.
  logic [TX_W-1:0] tile_x_q, tile_x_d;
  logic [TY_W-1:0] tile_y_q, tile_y_d;
  logic [CX_W-1:0] cell_x_q, cell_x_d;
  logic [CY_W-1:0] cell_y_q, cell_y_d;
  logic            out_valid_q, out_valid_d;
  logic            pixel_en_q, pixel_en_d;
  logic            tile_ovf_q, tile_ovf_d;
  // Cleared by reset; the first pixel after reset is taken as (0,0)
  // even without sof, so position counting restarts cleanly.
  logic            started_q, started_d;

  logic [TX_W-1:0] shd_x0_q, shd_x0_d, shd_x1_q, shd_x1_d;
  logic [TY_W-1:0] shd_y0_q, shd_y0_d, shd_y1_q, shd_y1_d;
  logic [TX_W-1:0] act_x0_q, act_x0_d, act_x1_q, act_x1_d;
  logic [TY_W-1:0] act_y0_q, act_y0_d, act_y1_q, act_y1_d;

  always_comb begin
    tile_x_d    = tile_x_q;
    tile_y_d    = tile_y_q;
    cell_x_d    = cell_x_q;
    cell_y_d    = cell_y_q;
    out_valid_d = 1'b0;
    pixel_en_d  = 1'b0;
    tile_ovf_d  = tile_ovf_q;
    started_d   = started_q;
    shd_x0_d    = shd_x0_q;
    shd_x1_d    = shd_x1_q;
    shd_y0_d    = shd_y0_q;
    shd_y1_d    = shd_y1_q;
    act_x0_d    = act_x0_q;
    act_x1_d    = act_x1_q;
    act_y0_d    = act_y0_q;
    act_y1_d    = act_y1_q;

    if (cfg_load) begin
      shd_x0_d = cfg_x0;
      shd_x1_d = cfg_x1;
      shd_y0_d = cfg_y0;
      shd_y1_d = cfg_y1;
    end

    if (pix_valid) begin
      out_valid_d = 1'b1;
      started_d   = 1'b1;
      if (sof || !started_q) begin
        tile_x_d = '0;
        tile_y_d = '0;
        cell_x_d = '0;
        cell_y_d = '0;
        if (sof) begin
          tile_ovf_d = 1'b0;
          // Taking the post-load shadow value lets a coincident cfg_load
          // become active on this very sof pixel.
          act_x0_d = shd_x0_d;
          act_x1_d = shd_x1_d;
          act_y0_d = shd_y0_d;
          act_y1_d = shd_y1_d;
        end
      end else if (sol) begin
        tile_x_d = '0;
        cell_x_d = '0;
        if (cell_y_q == CY_LAST) begin
          cell_y_d = '0;
          if (tile_y_q == '1) begin
            tile_ovf_d = 1'b1;
          end else begin
            tile_y_d = tile_y_q + 1'b1;
          end
        end else begin
          cell_y_d = cell_y_q + 1'b1;
        end
      end else begin
        if (cell_x_q == CX_LAST) begin
          cell_x_d = '0;
          if (tile_x_q == '1) begin
            tile_ovf_d = 1'b1;
          end else begin
            tile_x_d = tile_x_q + 1'b1;
          end
        end else begin
          cell_x_d = cell_x_q + 1'b1;
        end
      end

      // Evaluated against the bounds that apply to this pixel, so an
      // inverted window (x0 > x1 or y0 > y1) naturally yields 0.
      pixel_en_d = (act_x0_d <= tile_x_d) && (tile_x_d <= act_x1_d) &&
                   (act_y0_d <= tile_y_d) && (tile_y_d <= act_y1_d);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tile_x_q    <= '0;
      tile_y_q    <= '0;
      cell_x_q    <= '0;
      cell_y_q    <= '0;
      out_valid_q <= 1'b0;
      pixel_en_q  <= 1'b0;
      tile_ovf_q  <= 1'b0;
      started_q   <= 1'b0;
      shd_x0_q    <= RST_X0;
      shd_x1_q    <= RST_X1;
      shd_y0_q    <= RST_Y0;
      shd_y1_q    <= RST_Y1;
      act_x0_q    <= RST_X0;
      act_x1_q    <= RST_X1;
      act_y0_q    <= RST_Y0;
      act_y1_q    <= RST_Y1;
    end else begin
      tile_x_q    <= tile_x_d;
      tile_y_q    <= tile_y_d;
      cell_x_q    <= cell_x_d;
      cell_y_q    <= cell_y_d;
      out_valid_q <= out_valid_d;
      pixel_en_q  <= pixel_en_d;
      tile_ovf_q  <= tile_ovf_d;
      started_q   <= started_d;
      shd_x0_q    <= shd_x0_d;
      shd_x1_q    <= shd_x1_d;
      shd_y0_q    <= shd_y0_d;
      shd_y1_q    <= shd_y1_d;
      act_x0_q    <= act_x0_d;
      act_x1_q    <= act_x1_d;
      act_y0_q    <= act_y0_d;
      act_y1_q    <= act_y1_d;
    end
  end

  assign tile_x    = tile_x_q;
  assign tile_y    = tile_y_q;
  assign cell_x    = cell_x_q;
  assign cell_y    = cell_y_q;
  assign out_valid = out_valid_q;
  assign pixel_en  = pixel_en_q;
  assign tile_ovf  = tile_ovf_q;

endmodule

// File: tb/tb_tile_mapper.sv
// tb_tile_mapper
// Directed bench for tile_mapper. Three instances share one stimulus stream:
//   u_dut1  defaults (8x8 cells, 6-bit tile counters)
//   u_dut2  TX_W=3 to exercise tile counter saturation and tile_ovf
//   u_dut3  6x12 cells (non power-of-two width)
// A small position model (line / pixel index) supplies expected values for
// the gapped-stream phase; other phases use hand-computed constants.
module tb_tile_mapper;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       pix_valid = 1'b0;
  logic       sof = 1'b0;
  logic       sol = 1'b0;
  logic       cfg_load = 1'b0;
  logic [5:0] cfg_x0 = '0, cfg_x1 = '0, cfg_y0 = '0, cfg_y1 = '0;

  logic [5:0] t1x, t1y;
  logic [2:0] c1x, c1y;
  logic       ov1, pe1, of1;
  logic [2:0] t2x;
  logic [5:0] t2y;
  logic [2:0] c2x, c2y;
  logic       ov2, pe2, of2;
  logic [5:0] t3x, t3y;
  logic [2:0] c3x;
  logic [3:0] c3y;
  logic       ov3, pe3, of3;

  tile_mapper u_dut1 (
    .clk(clk), .rst_n(rst_n), .pix_valid(pix_valid), .sof(sof), .sol(sol),
    .cfg_x0(cfg_x0), .cfg_x1(cfg_x1), .cfg_y0(cfg_y0), .cfg_y1(cfg_y1),
    .cfg_load(cfg_load), .tile_x(t1x), .tile_y(t1y), .cell_x(c1x),
    .cell_y(c1y), .out_valid(ov1), .pixel_en(pe1), .tile_ovf(of1)
  );

  tile_mapper #(.TX_W(3), .WX0(1), .WX1(6)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .pix_valid(pix_valid), .sof(sof), .sol(sol),
    .cfg_x0(cfg_x0[2:0]), .cfg_x1(cfg_x1[2:0]), .cfg_y0(cfg_y0),
    .cfg_y1(cfg_y1), .cfg_load(cfg_load), .tile_x(t2x), .tile_y(t2y),
    .cell_x(c2x), .cell_y(c2y), .out_valid(ov2), .pixel_en(pe2),
    .tile_ovf(of2)
  );

  tile_mapper #(.CELL_W(6), .CELL_H(12)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .pix_valid(pix_valid), .sof(sof), .sol(sol),
    .cfg_x0(cfg_x0), .cfg_x1(cfg_x1), .cfg_y0(cfg_y0), .cfg_y1(cfg_y1),
    .cfg_load(cfg_load), .tile_x(t3x), .tile_y(t3y), .cell_x(c3x),
    .cell_y(c3y), .out_valid(ov3), .pixel_en(pe3), .tile_ovf(of3)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  // Position model: line / pixel index of the last absorbed pixel plus the
  // shadow and active window bounds as the design should hold them.
  int   m_line = 0, m_px = 0;
  bit   m_started = 0, m_ovf = 0;
  int   s_x0 = 1, s_x1 = 39, s_y0 = 3, s_y1 = 37;
  int   a_x0 = 1, a_x1 = 39, a_y0 = 3, a_y1 = 37;
  bit   load_req = 0;
  bit   auto_chk = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
  endtask

  function automatic int min_i(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  function automatic bit in_win(input int tx, input int ty);
    return (a_x0 <= tx) && (tx <= a_x1) && (a_y0 <= ty) && (ty <= a_y1);
  endfunction

  // Compare dut1/dut3 against the model; valid says whether a pixel was
  // absorbed on the last edge.
  task automatic check_model(input bit valid);
    int tx1, ty1, tx3, ty3;
    tx1 = min_i(m_px / 8, 63);
    ty1 = min_i(m_line / 8, 63);
    tx3 = min_i(m_px / 6, 63);
    ty3 = min_i(m_line / 12, 63);
    chk("m_t1x", t1x, tx1);
    chk("m_c1x", c1x, m_px % 8);
    chk("m_t1y", t1y, ty1);
    chk("m_c1y", c1y, m_line % 8);
    chk("m_ov1", ov1, valid);
    chk("m_pe1", pe1, valid && in_win(tx1, ty1));
    chk("m_of1", of1, m_ovf);
    chk("m_t3x", t3x, tx3);
    chk("m_c3x", c3x, m_px % 6);
    chk("m_t3y", t3y, ty3);
    chk("m_c3y", c3y, m_line % 12);
    chk("m_ov3", ov3, valid);
    chk("m_pe3", pe3, valid && in_win(tx3, ty3));
    chk("m_of3", of3, 1'b0);
  endtask

  task automatic pix(input logic sf, input logic sl);
    pix_valid = 1'b1; sof = sf; sol = sl; cfg_load = load_req;
    @(posedge clk); #1;
    pix_valid = 1'b0; sof = 1'b0; sol = 1'b0; cfg_load = 1'b0;
    if (load_req) begin
      s_x0 = cfg_x0; s_x1 = cfg_x1; s_y0 = cfg_y0; s_y1 = cfg_y1;
    end
    if (sf) begin
      m_line = 0; m_px = 0; m_ovf = 0;
      a_x0 = s_x0; a_x1 = s_x1; a_y0 = s_y0; a_y1 = s_y1;
    end else if (!m_started) begin
      m_line = 0; m_px = 0;
    end else if (sl) begin
      m_line++; m_px = 0;
    end else begin
      m_px++;
    end
    m_started = 1;
    if (m_px >= 512 || m_line >= 512) m_ovf = 1;
    load_req = 0;
    if (auto_chk) check_model(1'b1);
  endtask

  task automatic idle();
    pix_valid = 1'b0; cfg_load = 1'b0;
    @(posedge clk); #1;
    if (auto_chk) check_model(1'b0);
  endtask

  task automatic adv(input int n);
    for (int i = 0; i < n; i++) pix(1'b0, 1'b0);
  endtask

  task automatic go_line(input int target);
    while (m_line < target) pix(1'b0, 1'b1);
  endtask

  task automatic set_cfg(input int x0, input int x1, input int y0, input int y1);
    cfg_x0 = 6'(x0); cfg_x1 = 6'(x1); cfg_y0 = 6'(y0); cfg_y1 = 6'(y1);
  endtask

  // Mid-stream load on an idle cycle: only the shadow bounds change.
  task automatic load_idle();
    cfg_load = 1'b1;
    @(posedge clk); #1;
    cfg_load = 1'b0;
    s_x0 = cfg_x0; s_x1 = cfg_x1; s_y0 = cfg_y0; s_y1 = cfg_y1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_ov1", ov1, 1'b0);
    chk("rst_pe1", pe1, 1'b0);
    chk("rst_of1", of1, 1'b0);
    chk("rst_t1x", t1x, 0);
    chk("rst_c1x", c1x, 0);
    chk("rst_t1y", t1y, 0);
    chk("rst_c1y", c1y, 0);
    chk("rst_t3x", t3x, 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    m_started = 0; m_line = 0; m_px = 0; m_ovf = 0;
    s_x0 = 1; s_x1 = 39; s_y0 = 3; s_y1 = 37;
    a_x0 = 1; a_x1 = 39; a_y0 = 3; a_y1 = 37;
  endtask

  initial begin
    // ---- reset state and quiet outputs before the first pixel ----
    repeat (2) @(posedge clk);
    #1;
    do_reset();
    idle();
    idle();
    chk("quiet_ov1", ov1, 1'b0);
    chk("quiet_t1x", t1x, 0);
    chk("quiet_pe1", pe1, 1'b0);
    $display("[reset] done, checks so far %0d", n_chk);

    // ---- 320-pixel lines: pixel 17 of line 26 ----
    pix(1'b1, 1'b0);
    chk("sof_ov1", ov1, 1'b1);
    chk("sof_t1x", t1x, 0);
    chk("sof_pe1", pe1, 1'b0);
    adv(319);
    go_line(25);
    adv(13);
    chk("l25_t3x", t3x, 2);
    chk("l25_c3x", c3x, 1);
    chk("l25_t3y", t3y, 2);
    chk("l25_c3y", c3y, 1);
    chk("l25_t1x", t1x, 1);
    chk("l25_c1x", c1x, 5);
    chk("l25_t1y", t1y, 3);
    chk("l25_c1y", c1y, 1);
    adv(306);
    go_line(26);
    adv(17);
    chk("l26_t1x", t1x, 2);
    chk("l26_c1x", c1x, 1);
    chk("l26_t1y", t1y, 3);
    chk("l26_c1y", c1y, 2);
    chk("l26_pe1", pe1, 1'b1);
    chk("l26_ov1", ov1, 1'b1);
    chk("l26_t3x", t3x, 2);
    chk("l26_c3x", c3x, 5);
    chk("l26_c3y", c3y, 2);
    idle();
    chk("gap_ov1", ov1, 1'b0);
    chk("gap_pe1", pe1, 1'b0);
    chk("gap_t1x", t1x, 2);
    chk("gap_c1x", c1x, 1);
    $display("[raster] line 26 pixel 17 -> tile (%0d,%0d) cell (%0d,%0d)", t1x, t1y, c1x, c1y);

    // ---- default window corners (short lines to reach low rows) ----
    pix(1'b1, 1'b0);
    go_line(16); adv(8);
    chk("w12_t1x", t1x, 1);
    chk("w12_t1y", t1y, 2);
    chk("w12_pe1", pe1, 1'b0);
    go_line(24); adv(8);
    chk("w13_pe1", pe1, 1'b1);
    go_line(40);
    chk("w05_t1y", t1y, 5);
    chk("w05_pe1", pe1, 1'b0);
    go_line(296); adv(312);
    chk("w3937_t1x", t1x, 39);
    chk("w3937_t1y", t1y, 37);
    chk("w3937_pe1", pe1, 1'b1);
    adv(8);
    chk("w4037_t1x", t1x, 40);
    chk("w4037_pe1", pe1, 1'b0);
    $display("[window] corner checks done");

    // ---- tile counter saturation on the 3-bit instance ----
    pix(1'b1, 1'b0);
    adv(55);
    chk("ovf55_t2x", t2x, 6);
    chk("ovf55_of2", of2, 1'b0);
    adv(1);
    chk("ovf56_t2x", t2x, 7);
    chk("ovf56_of2", of2, 1'b0);
    adv(7);
    chk("ovf63_c2x", c2x, 7);
    chk("ovf63_of2", of2, 1'b0);
    adv(1);
    chk("ovf64_t2x", t2x, 7);
    chk("ovf64_c2x", c2x, 0);
    chk("ovf64_of2", of2, 1'b1);
    chk("ovf64_pe2", pe2, 1'b0);
    chk("ovf64_t2y", t2y, 0);
    chk("ovf64_c2y", c2y, 0);
    chk("ovf64_ov2", ov2, 1'b1);
    adv(15);
    chk("ovf79_t2x", t2x, 7);
    chk("ovf79_of2", of2, 1'b1);
    chk("ovf79_t1x", t1x, 9);
    chk("ovf79_of1", of1, 1'b0);
    pix(1'b0, 1'b1);
    chk("ovfsol_t2x", t2x, 0);
    chk("ovfsol_of2", of2, 1'b1);
    pix(1'b1, 1'b0);
    chk("ovfsof_of2", of2, 1'b0);
    $display("[ovf] saturation checks done");

    // ---- shadow bounds: mid-frame load waits for the next sof ----
    go_line(80); adv(24);
    chk("cfg_pre_pe1", pe1, 1'b1);
    set_cfg(5, 39, 3, 37);
    load_idle();
    adv(1);
    chk("cfg_mid_pe1", pe1, 1'b1);
    adv(6);
    chk("cfg_end_t1x", t1x, 3);
    chk("cfg_end_pe1", pe1, 1'b1);
    pix(1'b1, 1'b0);
    go_line(80); adv(24);
    chk("cfg_new_pe1", pe1, 1'b0);
    adv(16);
    chk("cfg_new5_pe1", pe1, 1'b1);
    set_cfg(0, 39, 0, 37);
    load_req = 1;
    pix(1'b1, 1'b0);
    chk("cfg_sof_pe1", pe1, 1'b1);
    set_cfg(10, 5, 0, 37);
    load_req = 1;
    pix(1'b1, 1'b0);
    adv(63);
    chk("cfg_inv_t1x", t1x, 7);
    chk("cfg_inv_pe1", pe1, 1'b0);
    $display("[cfg] shadow/active bound checks done");

    // ---- gapped stream, sof+sol together, reset mid-line ----
    set_cfg(2, 3, 0, 1);
    load_req = 1;
    auto_chk = 1;
    for (int l = 0; l < 20; l++) begin
      for (int p = 0; p < 40; p++) begin
        if (l == 0 && p == 0) pix(1'b1, 1'b1);
        else pix(1'b0, p == 0);
        idle();
        idle();
      end
    end
    pix(1'b0, 1'b1);
    for (int p = 0; p < 10; p++) begin
      pix(1'b0, 1'b0);
      idle();
      idle();
    end
    do_reset();
    idle();
    for (int l = 0; l < 26; l++) begin
      for (int p = 0; p < 40; p++) begin
        pix(1'b0, (p == 0) && (l > 0));
        idle();
        idle();
      end
    end
    pix(1'b1, 1'b0);
    go_line(24); adv(8);
    chk("post_rst_pe1", pe1, 1'b1);
    auto_chk = 0;
    $display("[gap] gapped stream and reset checks done");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/tile_mapper.md
TILE_MAPPER -- requirements
Module: tile_mapper

Interface
REQ-001 Parameter CELL_W, default 8, glyph cell width in pixels (2..64, any integer; not restricted to powers of two).
REQ-002 Parameter CELL_H, default 8, glyph cell height in pixels (2..64).
REQ-003 Parameter TX_W, default 6, tile-column counter width; parameter TY_W, default 6, tile-row counter width.
REQ-004 Parameters CX_W = clog2(CELL_W) and CY_W = clog2(CELL_H) are derived widths, not overridable.
REQ-005 Parameters WX0/WX1/WY0/WY1, defaults 1/39/3/37, are the reset values of the active window bounds (inclusive).
REQ-006 clk  in  1  sole clock, all state on rising edge.
REQ-007 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-008 pix_valid  in  1  a pixel is presented this cycle.
REQ-009 sof  in  1  start of frame; qualified by pix_valid.
REQ-010 sol  in  1  start of line; qualified by pix_valid.
REQ-011 cfg_x0, cfg_x1  in  TX_W each  staged column bounds; cfg_y0, cfg_y1  in  TY_W each  staged row bounds.
REQ-012 cfg_load  in  1  capture cfg_* into shadow registers.
REQ-013 tile_x  out  TX_W; tile_y  out  TY_W  tile coordinates of the output pixel.
REQ-014 cell_x  out  CX_W; cell_y  out  CY_W  offsets within the cell.
REQ-015 out_valid  out  1; pixel_en  out  1  output pixel lies inside the active window.
REQ-016 tile_ovf  out  1  sticky per frame: a tile counter saturated.

Function
REQ-017 Positions are tracked with counters only; no divide or modulo operators.
REQ-018 Latency is exactly 1 cycle: out_valid, and all coordinate outputs and pixel_en for that pixel, are registered at the edge following the input's pix_valid=1 cycle.
REQ-019 When pix_valid=0: counters, out_valid (0) and coordinate outputs hold (coordinates keep previous values); pixel_en = 0.
REQ-020 Pixel with sof=1 is position (0,0): tile_x, tile_y, cell_x, cell_y all 0; tile_ovf clears.
REQ-021 Pixel with sol=1, sof=0: cell_x = 0, tile_x = 0; cell_y advances by one; when cell_y was CELL_H-1 it wraps to 0 and tile_y increments.
REQ-022 sof and sol asserted together: sof dominates, vertical counters are not advanced.
REQ-023 Other qualified pixel: cell_x advances by one; when cell_x was CELL_W-1 it wraps to 0 and tile_x increments.
REQ-024 Tile counters saturate at all-ones (no wrap); any increment attempt at all-ones sets tile_ovf, which holds until the next sof pixel or reset.
REQ-025 pixel_en = out_valid AND (x0 <= tile_x <= x1) AND (y0 <= tile_y <= y1), evaluated against active bounds and the same pixel's coordinates; x0 > x1 or y0 > y1 yields pixel_en = 0.
REQ-026 cfg_load=1 copies cfg_* into shadow registers that cycle; active bounds take the shadow values only on a qualified sof pixel, and apply from that pixel onward.
REQ-027 cfg_load coincident with a sof pixel: the newly loaded values become active on that same pixel.
REQ-028 Mid-frame cfg_load never alters pixel_en for the current frame.

Reset
REQ-029 While rst_n=0: out_valid, pixel_en, tile_ovf = 0; tile_x, tile_y, cell_x, cell_y and internal counters = 0; shadow and active bounds = WX0/WX1/WY0/WY1.
REQ-030 Reset asserted mid-frame discards position; after release, a pixel with no preceding sof is treated as position (0,0) and following pixels count from there.
REQ-031 No output other than out_valid toggles before the first pix_valid=1 cycle after reset.

Verification
REQ-032 Defaults, 320-pixel lines, sof then sol every 320 pixels: pixel 17 of line 26 -> tile_x=2, cell_x=1, tile_y=3, cell_y=2, pixel_en=1, one cycle later.
REQ-033 Defaults: tile (0,5) -> pixel_en=0; (39,37) -> 1; (40,37) -> 0; (1,2) -> 0; (1,3) -> 1.
REQ-034 CELL_W=6, CELL_H=12: pixel 13 of line 25 -> tile_x=2, cell_x=1, tile_y=2, cell_y=1.
REQ-035 cfg_load x0=5 mid-frame -> tile (3,10) keeps pixel_en=1 through frame end; after next sof -> pixel_en=0 at (3,10).
REQ-036 TX_W=3, 80-pixel line at CELL_W=8 -> tile_x holds 7 from pixel 56, tile_ovf=1 at pixel 64; next sof -> tile_ovf=0.
REQ-037 pix_valid gaps (1 of 3 cycles), sof+sol together, rst_n pulse mid-line -> coordinates match gap-free golden sequence; reset behaves per REQ-029/030.
